defuzz_wavg: RTL and testbench



---
 rtl/defuzz_wavg.sv | 124 ++++++++++++
 tb/tb_defuzz_wavg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/defuzz_wavg.sv
// defuzz_wavg: weighted-average defuzzifier, serial MAC then restoring divider; `FZ_DEFUZZ_ROUND_EN rounds half away from zero
module defuzz_wavg #(
    parameter logic signed [15:0] G_NN = -16'sd24576,
    parameter logic signed [15:0] G_NP = -16'sd8192,
    parameter logic signed [15:0] G_PN = 16'sd8192,
    parameter logic signed [15:0] G_PP = 16'sd24576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] w_nn,
    input  logic [15:0] w_np,
    input  logic [15:0] w_pn,
    input  logic [15:0] w_pp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] u_out,
    output logic        zero_w,
    output logic        busy
);
`ifdef FZ_DEFUZZ_ROUND_EN
    localparam int NIT = 18;
`else
    localparam int NIT = 17;
`endif
    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [3:0][15:0] wr;
    logic [17:0] den;
    logic signed [33:0] num, num_nx;
    logic [1:0] idx;
    logic sign;
    logic [17:0] rem, rem_nx, lo;
    logic [NIT-1:0] q, q_nx;
    logic [4:0] cnt;
    logic signed [15:0] g;
    logic [32:0] mag_nx;
    logic [18:0] trial, qr;
    logic qbit;
    logic [15:0] u_nx;
    always_comb begin
        g = idx == 2'd0 ? G_NN : idx == 2'd1 ? G_NP : idx == 2'd2 ? G_PN : G_PP;
        num_nx = num + 34'($signed({1'b0, wr[idx]})) * 34'(g);
        mag_nx = num_nx[33] ? 33'(-num_nx) : num_nx[32:0];
        trial = {rem, lo[17]};
        qbit = trial >= {1'b0, den};
        rem_nx = qbit ? 18'(trial - {1'b0, den}) : trial[17:0];
        q_nx = {q[NIT-2:0], qbit};
`ifdef FZ_DEFUZZ_ROUND_EN
        qr = (19'(q_nx) + 19'd1) >> 1;
`else
        qr = 19'(q_nx);
`endif
        u_nx = sign ? (qr > 19'd32768 ? 16'h8000 : 16'(-qr))
                    : (qr > 19'd32767 ? 16'h7fff : qr[15:0]);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = in_valid ? ACC : IDLE;
            ACC: state_nx = idx != 2'd3 ? ACC : den == 18'd0 ? DONE : DIV;
            DIV: state_nx = cnt == 5'(NIT - 1) ? DONE : DIV;
            DONE: state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
        busy = state == ACC || state == DIV;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr <= '0;
            den <= '0;
            num <= '0;
            idx <= '0;
            sign <= 1'b0;
            rem <= '0;
            lo <= '0;
            q <= '0;
            cnt <= '0;
            u_out <= '0;
            zero_w <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    wr <= {w_pp, w_pn, w_np, w_nn};
                    den <= 18'(w_nn) + 18'(w_np) + 18'(w_pn) + 18'(w_pp);
                    num <= '0;
                    idx <= '0;
                end
                ACC: begin
                    num <= num_nx;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3 && den == 18'd0) begin
                        u_out <= '0;
                        zero_w <= 1'b1;
                    end else if (idx == 2'd3) begin
                        sign <= num_nx[33];
                        rem <= {2'b0, mag_nx[32:17]};
                        lo <= {mag_nx[16:0], 1'b0};
                        q <= '0;
                        cnt <= '0;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    lo <= lo << 1;
                    q <= q_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(NIT - 1)) begin
                        u_out <= u_nx;
                        zero_w <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_defuzz_wavg.sv
// tb_defuzz_wavg: directed and random checks of defuzz_wavg against an arithmetic reference model
module tb_defuzz_wavg;
`ifdef FZ_DEFUZZ_ROUND_EN
    localparam int LAT = 22;
`else
    localparam int LAT = 21;
`endif
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] w_nn = '0, w_np = '0, w_pn = '0, w_pp = '0;
    logic ir[4], ov[4], zw[4], bz[4];
    logic [15:0] uo[4];
    logic [15:0] ru[4];
    logic rz[4];
    int lat, total = 0, bad = 0;
    bit hs, st, rl;
    int gt[4][4] = '{'{-24576, -8192, 8192, 24576}, '{-24576, -8192, 8192, -32768},
                     '{-24576, -8192, 8192, 32767}, '{0, -8192, 8192, 1}};
    always #5 clk = ~clk;
    defuzz_wavg d0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .w_nn(w_nn), .w_np(w_np),
        .w_pn(w_pn), .w_pp(w_pp), .out_valid(ov[0]), .out_ready(out_ready), .u_out(uo[0]), .zero_w(zw[0]), .busy(bz[0]));
    defuzz_wavg #(.G_PP(16'sh8000)) d1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .w_nn(w_nn),
        .w_np(w_np), .w_pn(w_pn), .w_pp(w_pp), .out_valid(ov[1]), .out_ready(out_ready), .u_out(uo[1]), .zero_w(zw[1]), .busy(bz[1]));
    defuzz_wavg #(.G_PP(16'sd32767)) d2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .w_nn(w_nn),
        .w_np(w_np), .w_pn(w_pn), .w_pp(w_pp), .out_valid(ov[2]), .out_ready(out_ready), .u_out(uo[2]), .zero_w(zw[2]), .busy(bz[2]));
    defuzz_wavg #(.G_NN(16'sd0), .G_PP(16'sd1)) d3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .w_nn(w_nn),
        .w_np(w_np), .w_pn(w_pn), .w_pp(w_pp), .out_valid(ov[3]), .out_ready(out_ready), .u_out(uo[3]), .zero_w(zw[3]), .busy(bz[3]));

    function automatic void model(input int k, input logic [15:0] a, b, c, d, output int u, output bit z, output int l);
        longint num, den, mag, qv;
        num = longint'(a) * gt[k][0] + longint'(b) * gt[k][1] + longint'(c) * gt[k][2] + longint'(d) * gt[k][3];
        den = longint'(a) + longint'(b) + longint'(c) + longint'(d);
        if (den == 0) begin
            u = 0; z = 1'b1; l = 4;
            return;
        end
        mag = num < 0 ? -num : num;
`ifdef FZ_DEFUZZ_ROUND_EN
        qv = (2 * mag + den) / (2 * den);
`else
        qv = mag / den;
`endif
        qv = num < 0 ? -qv : qv;
        u = qv > 32767 ? 32767 : qv < -32768 ? -32768 : int'(qv);
        z = 1'b0; l = LAT;
    endfunction

    task automatic do_txn(input logic [15:0] a, b, c, d, input int hold);
        @(negedge clk);
        hs = ir[0] === 1'b1 && bz[0] === 1'b0 && ov[0] === 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        w_nn = a; w_np = b; w_pn = c; w_pp = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_nn = 16'($urandom); w_np = 16'($urandom); w_pn = 16'($urandom); w_pp = 16'($urandom);
        lat = 0;
        while (lat < 40) begin
            if (ir[0] !== 1'b0 || bz[0] !== 1'b1 || ov[0] !== 1'b0) hs = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (ov[0] === 1'b1) break;
        end
        for (int k = 0; k < 4; k++) begin ru[k] = uo[k]; rz[k] = zw[k]; end
        st = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++)
                if (uo[k] !== ru[k] || zw[k] !== rz[k] || ov[k] !== 1'b1 || ir[k] !== 1'b0) st = 1'b0;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        rl = ov[0] === 1'b0 && ir[0] === 1'b1 && bz[0] === 1'b0 && uo[0] === ru[0];
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || uo[k] !== 16'h0 || zw[k] !== 1'b0 || bz[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset%0d: got ir=%b ov=%b u=%h z=%b busy=%b want 1 0 0000 0 0", k, ir[k], ov[k], uo[k], zw[k], bz[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        do_txn(16'h0, 16'h0, 16'h0, 16'h8000, 0);
        total++; if (int'($signed(ru[0])) !== 24576) begin bad++; $display("FAIL single_u: got %0d want 24576", $signed(ru[0])); end
        total++; if (rz[0] !== 1'b0) begin bad++; $display("FAIL single_z: got %b want 0", rz[0]); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL single_lat: got %0d want %0d", lat, LAT); end
        total++; if (!hs || !rl) begin bad++; $display("FAIL single_hs: got hs=%b rel=%b want 1 1", hs, rl); end
    endtask

    task automatic test_mixed;
        do_txn(16'h6000, 16'h2000, 16'h0, 16'h0, 2);
        total++; if (int'($signed(ru[0])) !== -20480) begin bad++; $display("FAIL mixed_u: got %0d want -20480", $signed(ru[0])); end
        total++; if (rz[0] !== 1'b0 || !st) begin bad++; $display("FAIL mixed_z: got z=%b stable=%b want 0 1", rz[0], st); end
    endtask

    task automatic test_cancel;
        do_txn(16'h4000, 16'h4000, 16'h4000, 16'h4000, 0);
        total++; if (ru[0] !== 16'h0 || rz[0] !== 1'b0) begin bad++; $display("FAIL cancel: got u=%h z=%b want 0000 0", ru[0], rz[0]); end
    endtask

    task automatic test_zero;
        do_txn(16'h0, 16'h0, 16'h0, 16'h0, 1);
        total++; if (ru[0] !== 16'h0 || rz[0] !== 1'b1) begin bad++; $display("FAIL zero_out: got u=%h z=%b want 0000 1", ru[0], rz[0]); end
        total++; if (lat !== 4) begin bad++; $display("FAIL zero_lat: got %0d want 4", lat); end
        do_txn(16'h0, 16'h0, 16'h0, 16'h8000, 0);
        total++; if (int'($signed(ru[0])) !== 24576 || rz[0] !== 1'b0 || !hs) begin
            bad++; $display("FAIL zero_next: got u=%0d z=%b hs=%b want 24576 0 1", $signed(ru[0]), rz[0], hs);
        end
    endtask

    task automatic test_backpressure;
        do_txn(16'h0, 16'h0, 16'h0, 16'h0001, 10);
        total++; if (int'($signed(ru[1])) !== -32768) begin bad++; $display("FAIL sat_neg: got %0d want -32768", $signed(ru[1])); end
        total++; if (int'($signed(ru[2])) !== 32767) begin bad++; $display("FAIL sat_pos: got %0d want 32767", $signed(ru[2])); end
        total++; if (!st) begin bad++; $display("FAIL bp_hold: got stable=%b want 1", st); end
        total++; if (!rl) begin bad++; $display("FAIL bp_release: got %b want 1", rl); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1'b1; w_nn = 16'h1234; w_np = 16'h0; w_pn = 16'h0; w_pp = 16'h8000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (ov[0] !== 1'b0 || uo[0] !== 16'h0 || ir[0] !== 1'b1 || bz[0] !== 1'b0 || zw[0] !== 1'b0) begin
            bad++; $display("FAIL rst_mid: got ov=%b u=%h ir=%b busy=%b want 0 0000 1 0", ov[0], uo[0], ir[0], bz[0]);
        end
        @(negedge clk) rst_n = 1'b1;
        do_txn(16'h0, 16'h0, 16'h0, 16'h8000, 0);
        total++; if (int'($signed(ru[0])) !== 24576 || lat !== LAT) begin
            bad++; $display("FAIL rst_after: got u=%0d lat=%0d want 24576 %0d", $signed(ru[0]), lat, LAT);
        end
    endtask

    task automatic test_trunc;
        do_txn(16'h8000, 16'h0, 16'h0, 16'h8000, 0);
`ifdef FZ_DEFUZZ_ROUND_EN
        total++; if (ru[3] !== 16'd1) begin bad++; $display("FAIL round: got %0d want 1", $signed(ru[3])); end
`else
        total++; if (ru[3] !== 16'd0) begin bad++; $display("FAIL trunc: got %0d want 0", $signed(ru[3])); end
`endif
        total++; if (lat !== LAT) begin bad++; $display("FAIL trunc_lat: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_random;
        logic [15:0] w[4];
        int eu, el;
        bit ez;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) w[i] = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 7) == 0) for (int i = 0; i < 4; i++) w[i] = 16'h0;
            if ($urandom_range(0, 3) == 0) for (int i = 0; i < 4; i++) w[i] = 16'($urandom_range(0, 7));
            do_txn(w[0], w[1], w[2], w[3], $urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                model(k, w[0], w[1], w[2], w[3], eu, ez, el);
                total++;
                if (int'($signed(ru[k])) !== eu || rz[k] !== ez) begin
                    bad++;
                    $display("FAIL rand%0d_dut%0d w=%h %h %h %h: got u=%0d z=%b want u=%0d z=%b",
                             n, k, w[0], w[1], w[2], w[3], $signed(ru[k]), rz[k], eu, ez);
                end
            end
            total++;
            if (lat !== el || !hs || !st || !rl) begin
                bad++; $display("FAIL rand%0d_hs: got lat=%0d hs=%b st=%b rel=%b want %0d 1 1 1", n, lat, hs, st, rl, el);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_mixed;
        test_cancel;
        test_zero;
        test_backpressure;
        test_reset_mid;
        test_trunc;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
